// File: rtl/nic8_ctrl_pkg.sv
// nic8_ctrl_pkg
//  Shared encodings for the nic8 control sequencer.
//  - DEST_* : IR destination field codes (index into load_en)
//  - SRC_*  : IR source field codes
//  - COND_* : IR condition field codes (only meaningful for dest PC)
//  - S_*    : sequencer state codes
//  - SEL_*  : bit positions inside the one-hot src_sel bus {x,a,e,ram,rom}
package nic8_ctrl_pkg;

    localparam logic [2:0] DEST_IR   = 3'd0;
    localparam logic [2:0] DEST_PC   = 3'd1;
    localparam logic [2:0] DEST_A    = 3'd2;
    localparam logic [2:0] DEST_B    = 3'd3;
    localparam logic [2:0] DEST_X    = 3'd4;
    localparam logic [2:0] DEST_MEM  = 3'd5;
    localparam logic [2:0] DEST_Q    = 3'd6;
    localparam logic [2:0] DEST_HALT = 3'd7;

    localparam logic [1:0] SRC_MEM = 2'd0;
    localparam logic [1:0] SRC_E   = 2'd1;
    localparam logic [1:0] SRC_A   = 2'd2;
    localparam logic [1:0] SRC_X   = 2'd3;

    localparam logic [1:0] COND_NEVER  = 2'd0;
    localparam logic [1:0] COND_Z      = 2'd1;
    localparam logic [1:0] COND_C      = 2'd2;
    localparam logic [1:0] COND_ALWAYS = 2'd3;

    typedef logic [1:0] ctrlState_t;
    localparam ctrlState_t S_RESET = 2'd0;
    localparam ctrlState_t S_FETCH = 2'd1;
    localparam ctrlState_t S_EXEC  = 2'd2;
    localparam ctrlState_t S_HALT  = 2'd3;

    localparam int SRC_SEL_W = 5;
    localparam int SEL_ROM   = 0;
    localparam int SEL_RAM   = 1;
    localparam int SEL_E     = 2;
    localparam int SEL_A     = 3;
    localparam int SEL_X     = 4;

    function automatic logic [SRC_SEL_W-1:0] selOneHot(input int bitIdx);
        return SRC_SEL_W'(1) << bitIdx;
    endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode
//  Pure combinational instruction decode for the nic8 sequencer.
//  Ports:
//   ir         in   8         {cond[1:0], src[1:0], idx, dest[2:0]}
//   destOneHot out  NUM_DEST  one-hot of the dest field
//   srcOneHot  out  5         one-hot bus driver {x,a,e,ram,rom}
//   cond       out  2         jump condition field
//   isMem      out  1         instruction touches RAM/ROM (must wait for mem_ready)
//   isImm      out  1         operand is the next ROM word (PC must advance past it)
//   isHalt     out  1         dest decodes as HALT
//   isPcDest   out  1         dest is the PC (conditional jump)
module control_decode
    import nic8_ctrl_pkg::*;
#(
    parameter int DEST_W    = 3,
    parameter int HALT_DEST = 7,
    localparam int NUM_DEST = 2 ** DEST_W
) (
    input  logic [7:0]           ir,
    output logic [NUM_DEST-1:0]  destOneHot,
    output logic [SRC_SEL_W-1:0] srcOneHot,
    output logic [1:0]           cond,
    output logic                 isMem,
    output logic                 isImm,
    output logic                 isHalt,
    output logic                 isPcDest
);

    logic [DEST_W-1:0] dest;
    logic [1:0]        src;
    logic              idx;

    assign dest = ir[DEST_W-1:0];
    assign idx  = ir[3];
    assign src  = ir[5:4];
    assign cond = ir[7:6];

    for (genvar gi = 0; gi < NUM_DEST; gi++) begin : gDest
        assign destOneHot[gi] = (dest == DEST_W'(gi));
    end

    always_comb begin
        srcOneHot = '0;
        case (src)
            SRC_MEM: srcOneHot = idx ? selOneHot(SEL_RAM) : selOneHot(SEL_ROM);
            SRC_E:   srcOneHot = selOneHot(SEL_E);
            SRC_A:   srcOneHot = selOneHot(SEL_A);
            SRC_X:   srcOneHot = selOneHot(SEL_X);
            default: srcOneHot = '0;
        endcase
    end

    // A store to memory is a memory access even when the bus source is a register.
    assign isMem    = (src == SRC_MEM) || (dest == DEST_W'(DEST_MEM));
    assign isImm    = (src == SRC_MEM) && !idx;
    assign isHalt   = (dest == DEST_W'(HALT_DEST));
    assign isPcDest = (dest == DEST_W'(DEST_PC));

endmodule

// File: rtl/control_fsm.sv
// control_fsm
//  FETCH/EXEC control sequencer for the nic8 datapath. Produces synchronous
//  one-hot load enables and bus selects; only the state and the optional
//  latched flags are registered, all strobes are decoded from state + ir
//  (and mem_ready for stalls).
//  Ports:
//   clk, reset               clock (rising) / asynchronous active-high reset
//   ir                       current instruction register
//   alu_zero, alu_carry      live ALU flags
//   mem_ready                RAM/ROM access completes this cycle
//   load_en                  one-hot register load enable (0=IR, 1=PC, 5=mem store)
//   src_sel                  one-hot bus driver {x,a,e,ram,rom}
//   do_subtract              ALU subtract (ir[6] during EXEC)
//   do_jump, pc_inc          PC control
//   flag_z, flag_c           flags used for conditional jumps
//   halted                   sequencer stopped until reset
module control_fsm
    import nic8_ctrl_pkg::*;
#(
    parameter int DEST_W    = 3,
    parameter int FLAG_MODE = 1,
    parameter int HALT_DEST = 7,
    localparam int NUM_DEST = 2 ** DEST_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           ir,
    input  logic                 alu_zero,
    input  logic                 alu_carry,
    input  logic                 mem_ready,
    output logic [NUM_DEST-1:0]  load_en,
    output logic [SRC_SEL_W-1:0] src_sel,
    output logic                 do_subtract,
    output logic                 do_jump,
    output logic                 pc_inc,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 halted
);

    logic [NUM_DEST-1:0]  destOneHot;
    logic [SRC_SEL_W-1:0] srcOneHot;
    logic [1:0]           cond;
    logic                 isMem, isImm, isHalt, isPcDest;

    control_decode #(
        .DEST_W    (DEST_W),
        .HALT_DEST (HALT_DEST)
    ) uDecode (
        .ir         (ir),
        .destOneHot (destOneHot),
        .srcOneHot  (srcOneHot),
        .cond       (cond),
        .isMem      (isMem),
        .isImm      (isImm),
        .isHalt     (isHalt),
        .isPcDest   (isPcDest)
    );

    ctrlState_t           stateReg, stateNext;
    logic [NUM_DEST-1:0]  loadEnInt;
    logic [SRC_SEL_W-1:0] srcSelInt;
    logic                 doSubInt, doJumpInt, pcIncInt, haltedInt;
    logic                 condZ, condC, flagZInt, flagCInt, taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= S_RESET;
        end else begin
            stateReg <= stateNext;
        end
    end

    if (FLAG_MODE != 0) begin : gLatchedFlags
        logic flagZReg, flagCReg;

        // Flags follow the ALU only when A is actually written, so a jump
        // tests the result of the last accumulator operation.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                flagZReg <= 1'b0;
                flagCReg <= 1'b0;
            end else if (loadEnInt[DEST_A]) begin
                flagZReg <= alu_zero;
                flagCReg <= alu_carry;
            end
        end

        assign condZ    = flagZReg;
        assign condC    = flagCReg;
        assign flagZInt = flagZReg;
        assign flagCInt = flagCReg;
    end else begin : gLiveFlags
        assign condZ    = alu_zero;
        assign condC    = alu_carry;
        assign flagZInt = alu_zero;
        assign flagCInt = alu_carry;
    end

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NEVER:  taken = 1'b0;
            COND_Z:      taken = condZ;
            COND_C:      taken = condC;
            COND_ALWAYS: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

    always_comb begin
        stateNext = stateReg;
        loadEnInt = '0;
        srcSelInt = '0;
        doSubInt  = 1'b0;
        doJumpInt = 1'b0;
        pcIncInt  = 1'b0;
        haltedInt = 1'b0;
        case (stateReg)
            S_RESET: stateNext = S_FETCH;
            S_FETCH: begin
                // ROM stays on the bus through a stall so the read is undisturbed.
                srcSelInt = selOneHot(SEL_ROM);
                if (mem_ready) begin
                    loadEnInt[DEST_IR] = 1'b1;
                    pcIncInt           = 1'b1;
                    stateNext          = S_EXEC;
                end
            end
            S_EXEC: begin
                srcSelInt = srcOneHot;
                doSubInt  = ir[6];
                if (isHalt) begin
                    // HALT consumes no operand, so it never waits on memory.
                    stateNext = S_HALT;
                end else if (!isMem || mem_ready) begin
                    stateNext = S_FETCH;
                    pcIncInt  = isImm;
                    if (!isPcDest) begin
                        loadEnInt = destOneHot;
                    end else if (taken) begin
                        loadEnInt = destOneHot;
                        doJumpInt = 1'b1;
                        pcIncInt  = 1'b0;
                    end
                end
            end
            S_HALT: haltedInt = 1'b1;
            default: stateNext = S_RESET;
        endcase
    end

    // Outputs are forced quiet while reset is high regardless of the flag source.
    assign load_en     = reset ? '0 : loadEnInt;
    assign src_sel     = reset ? '0 : srcSelInt;
    assign do_subtract = !reset && doSubInt;
    assign do_jump     = !reset && doJumpInt;
    assign pc_inc      = !reset && pcIncInt;
    assign halted      = !reset && haltedInt;
    assign flag_z      = !reset && flagZInt;
    assign flag_c      = !reset && flagCInt;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ir;
    logic       alu_zero, alu_carry, mem_ready;
    logic [7:0] load_en;
    logic [4:0] src_sel;
    logic       do_subtract, do_jump, pc_inc, flag_z, flag_c, halted;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .ir          (ir),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .mem_ready   (mem_ready),
        .load_en     (load_en),
        .src_sel     (src_sel),
        .do_subtract (do_subtract),
        .do_jump     (do_jump),
        .pc_inc      (pc_inc),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .halted      (halted)
    );

    typedef struct packed {
        logic [7:0] le;
        logic [4:0] ss;
        logic       sub;
        logic       jmp;
        logic       inc;
        logic       fz;
        logic       fc;
        logic       hlt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycleNo = 0;
    logic mdlZ = 1'b0;
    logic mdlC = 1'b0;

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cycleNo, act, req);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cycleNo++;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("load_en", load_en, e.le);
                chk("src_sel", {3'b0, src_sel}, {3'b0, e.ss});
                chk("do_subtract", {7'b0, do_subtract}, {7'b0, e.sub});
                chk("do_jump", {7'b0, do_jump}, {7'b0, e.jmp});
                chk("pc_inc", {7'b0, pc_inc}, {7'b0, e.inc});
                chk("flag_z", {7'b0, flag_z}, {7'b0, e.fz});
                chk("flag_c", {7'b0, flag_c}, {7'b0, e.fc});
                chk("halted", {7'b0, halted}, {7'b0, e.hlt});
            end
        end
    end

    // ---------------- reference model / stimulus ----------------
    function automatic exp_t quiet();
        exp_t e;
        e = '0;
        e.fz = mdlZ;
        e.fc = mdlC;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic drive(input logic [7:0] irV, input logic mr, input logic az,
                         input logic ac, input logic rst, input exp_t e);
        ir        = irV;
        mem_ready = mr;
        alu_zero  = az;
        alu_carry = ac;
        reset     = rst;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // n cycles with reset high, then the one idle cycle after release.
    task automatic doReset(input int n);
        exp_t e;
        mdlZ = 1'b0;
        mdlC = 1'b0;
        e = '0;
        for (int i = 0; i < n; i++) drive(8'($urandom), rb(), rb(), rb(), 1'b1, e);
        drive(8'($urandom), rb(), rb(), rb(), 1'b0, e);
    endtask

    task automatic doFetch(input int stalls);
        exp_t e;
        e = quiet();
        e.ss = 5'b00001;
        for (int i = 0; i < stalls; i++) drive(8'($urandom), 1'b0, rb(), rb(), 1'b0, e);
        e.le  = 8'h01;
        e.inc = 1'b1;
        drive(8'($urandom), 1'b1, rb(), rb(), 1'b0, e);
    endtask

    task automatic doHalt(input int n);
        exp_t e;
        e = quiet();
        e.hlt = 1'b1;
        for (int i = 0; i < n; i++) drive(8'($urandom), rb(), rb(), rb(), 1'b0, e);
    endtask

    task automatic doExec(input logic [7:0] irV, input int stalls, input logic az,
                          input logic ac, input bit abort, output bit wentHalt);
        exp_t       e;
        logic [2:0] dest;
        logic [1:0] src, cond;
        logic       idx, isMem, isImm, taken, mr;
        dest  = irV[2:0];
        idx   = irV[3];
        src   = irV[5:4];
        cond  = irV[7:6];
        isMem = (src == 2'd0) || (dest == 3'd5);
        isImm = (src == 2'd0) && !idx;
        wentHalt = 1'b0;
        e = quiet();
        e.sub = irV[6];
        case (src)
            2'd0: e.ss = idx ? 5'b00010 : 5'b00001;
            2'd1: e.ss = 5'b00100;
            2'd2: e.ss = 5'b01000;
            default: e.ss = 5'b10000;
        endcase
        if (dest == 3'd7) begin
            drive(irV, rb(), az, ac, 1'b0, e);
            wentHalt = 1'b1;
            $display("instr ir=%h halt", irV);
            return;
        end
        if (isMem) begin
            for (int i = 0; i < stalls; i++) drive(irV, 1'b0, rb(), rb(), 1'b0, e);
        end
        if (abort) begin
            $display("instr ir=%h stalls=%0d reset-abort", irV, stalls);
            doReset(2);
            return;
        end
        mr = isMem ? 1'b1 : rb();
        taken = (cond == 2'd3) || (cond == 2'd1 && mdlZ) || (cond == 2'd2 && mdlC);
        if (dest == 3'd1) begin
            if (taken) begin
                e.le  = 8'h02;
                e.jmp = 1'b1;
                e.inc = 1'b0;
            end else begin
                e.inc = isImm;
            end
        end else begin
            e.le  = 8'h01 << dest;
            e.inc = isImm;
        end
        drive(irV, mr, az, ac, 1'b0, e);
        if (dest == 3'd2) begin
            mdlZ = az;
            mdlC = ac;
        end
        $display("instr ir=%h stalls=%0d le=%h inc=%0d jmp=%0d z=%0d c=%0d",
                 irV, isMem ? stalls : 0, e.le, e.inc, e.jmp, mdlZ, mdlC);
    endtask

    initial begin
        bit h;
        reset = 1'b1;
        ir = 8'h00;
        mem_ready = 1'b0;
        alu_zero = 1'b0;
        alu_carry = 1'b0;
        @(posedge clk);
        #1;
        doReset(2);

        // A load from E latches flags
        doFetch(0); doExec(8'h12, 0, 1'b1, 1'b0, 1'b0, h);
        // unconditional jump with immediate operand
        doFetch(1); doExec(8'hC1, 1, 1'b0, 1'b0, 1'b0, h);
        // clear Z then jump-if-Z not taken
        doFetch(0); doExec(8'h12, 0, 1'b0, 1'b1, 1'b0, h);
        doFetch(0); doExec(8'h41, 0, 1'b1, 1'b1, 1'b0, h);
        // jump-if-C taken (C latched 1 above)
        doFetch(0); doExec(8'h81, 2, 1'b0, 1'b0, 1'b0, h);
        // store with 3 stall cycles
        doFetch(0); doExec(8'h25, 3, 1'b0, 1'b0, 1'b0, h);
        // RAM operand vs ROM immediate into A
        doFetch(2); doExec(8'h0A, 1, 1'b1, 1'b1, 1'b0, h);
        doFetch(0); doExec(8'h02, 0, 1'b0, 1'b0, 1'b0, h);
        // flags set, then reset mid-stall of a store
        doFetch(0); doExec(8'h12, 0, 1'b1, 1'b1, 1'b0, h);
        doFetch(0); doExec(8'h25, 2, 1'b0, 1'b0, 1'b1, h);
        // halt is sticky until reset
        doFetch(0); doExec(8'h07, 0, 1'b0, 1'b0, 1'b0, h);
        doHalt(20);
        doReset(1);

        for (int n = 0; n < 250; n++) begin
            logic [7:0] irV;
            bit         ab;
            irV = 8'($urandom);
            ab  = ($urandom_range(0, 15) == 0);
            doFetch($urandom_range(0, 2));
            doExec(irV, $urandom_range(0, 3), rb(), rb(), ab, h);
            if (h) begin
                doHalt($urandom_range(1, 6));
                doReset(1);
            end
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
